// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit XNOR LFSR generator and its checker.
package lfsr_pkg;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lfsr_state_e;

  localparam logic [3:0] LFSR_LOCKUP = 4'hF;
  localparam logic [3:0] LFSR_RESET  = 4'h0;

  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2:0], ~(x[3] ^ x[2])};
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter; clear wins over increment.
module lfsr_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && ~&cnt)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 4-bit XNOR LFSR stream: lock, flywheel
// prediction, error counting and lockup-word detection.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_ERRORS  = 3,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           in_data,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 stuck
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRORS);

  lfsr_state_e state, state_d;
  logic [3:0]  ref_q, ref_d;
  logic        ref_vld, vld_d;
  logic [3:0]  match_cnt, match_d;
  logic [3:0]  miss_cnt, miss_d;
  logic        pulse_d, stuck_d, err_inc;
  logic [3:0]  pred;
  logic        is_f, hit;

  assign pred = lfsr_next(ref_q);
  assign is_f = (in_data == LFSR_LOCKUP);
  assign hit  = (in_data == pred);

  always_comb begin
    state_d = state;
    ref_d   = ref_q;
    vld_d   = ref_vld;
    match_d = match_cnt;
    miss_d  = miss_cnt;
    pulse_d = 1'b0;
    err_inc = 1'b0;
    stuck_d = stuck;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          if (is_f) begin
            vld_d   = 1'b0;
            match_d = '0;
            stuck_d = 1'b1;
          end else begin
            match_d = (ref_vld && hit) ? 4'(match_cnt + 4'd1) : 4'd0;
            ref_d   = in_data;
            vld_d   = 1'b1;
            if (match_d == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the reference advances on its own so a single bad word
          // costs exactly one error instead of two.
          ref_d = pred;
          if (hit) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            miss_d  = 4'(miss_cnt + 4'd1);
            if (is_f) stuck_d = 1'b1;
            if (miss_d == LOSS_N) begin
              state_d = SEARCH;
              match_d = '0;
              ref_d   = in_data;
              vld_d   = !is_f;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (clear_cnt) stuck_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      ref_q     <= LFSR_RESET;
      ref_vld   <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      state     <= state_d;
      ref_q     <= ref_d;
      ref_vld   <= vld_d;
      match_cnt <= match_d;
      miss_cnt  <= miss_d;
      err_pulse <= pulse_d;
      stuck     <= stuck_d;
    end
  end

  assign locked = (state == LOCKED);

  lfsr_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_cnt),
    .inc (err_inc),
    .cnt (err_count)
  );

endmodule
